// File: rtl/leitura_matr_pkg.sv
// ---------------------------------------------------------------------------
// pkg_parque
// Definitions shared by the parking controller blocks: the entry-side writer,
// the plate store and the exit-side reader (leitura_matr).
//   MATR_W            : width of a licence plate word
//   DIA_W             : width of the day-of-week field
//   estado_leitura_t  : state encoding of the exit-side plate reader
// ---------------------------------------------------------------------------
package pkg_parque;

  localparam int MATR_W = 24;
  localparam int DIA_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LER,
    COMP,
    LIMPA,
    ABRE,
    FALHA
  } estado_leitura_t;

endpackage

// File: rtl/leitura_matr_temporizador.sv
// ---------------------------------------------------------------------------
// temporizador_barreira
// Loadable down-counter that times how long a barrier stays open. It is used
// by the exit reader and also by the entry side.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val into the counter (has priority over dec)
//   dec        : decrement by one; the counter saturates at zero
//   load_val   : value loaded on load
//   count      : current counter value
//   zero       : high while the counter is zero
// ---------------------------------------------------------------------------
module temporizador_barreira #(
  parameter int T_MAX = 16,
  parameter int W     = $clog2(T_MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a load overrides a decrement, and a decrement at zero is
  // dropped so the counter can never wrap to its maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/leitura_matr.sv
// ---------------------------------------------------------------------------
// leitura_matr
// Exit-side plate reader. On an exit request it scans the plate store slot by
// slot through a synchronous read port (one cycle of read latency). The first
// valid slot holding the plate is invalidated, a fine is flagged when the entry
// day differs from the current day, and the exit barrier is held open for
// T_ABERTA cycles. If no slot matches, NaoEncontrada pulses for one cycle.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   Matricula, Dia      : plate and current day, captured on accept
//   MatrVal             : exit request, only looked at while idle
//   Rd_En, Rd_Addr      : store read request
//   Rd_Data, Rd_Valid,
//   Rd_Dia              : store read response, valid the cycle after Rd_En
//   Clr_En, Clr_Addr    : one-cycle slot invalidate
//   Ocupado             : request in progress
//   Barreira2           : exit barrier open
//   Multa               : one-cycle fine pulse
//   NaoEncontrada       : one-cycle plate-not-found pulse
// ---------------------------------------------------------------------------
module leitura_matr
  import pkg_parque::*;
#(
  parameter int N_LUG    = 8,
  parameter int AW       = 3,
  parameter int T_ABERTA = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [MATR_W-1:0] Matricula,
  input  logic              MatrVal,
  input  logic [DIA_W-1:0]  Dia,
  output logic              Rd_En,
  output logic [AW-1:0]     Rd_Addr,
  input  logic [MATR_W-1:0] Rd_Data,
  input  logic              Rd_Valid,
  input  logic [DIA_W-1:0]  Rd_Dia,
  output logic              Clr_En,
  output logic [AW-1:0]     Clr_Addr,
  output logic              Ocupado,
  output logic              Barreira2,
  output logic              Multa,
  output logic              NaoEncontrada
);

  localparam int TW = $clog2(T_ABERTA + 1);

  estado_leitura_t   estado_q, estado_d;
  logic [MATR_W-1:0] matr_q, matr_d;
  logic [DIA_W-1:0]  dia_q, dia_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     hit_q, hit_d;
  logic [DIA_W-1:0]  dia_hit_q, dia_hit_d;

  logic              tmr_load;
  logic              tmr_dec;
  logic [TW-1:0]     tmr_count;
  logic              tmr_zero;

  temporizador_barreira #(
    .T_MAX (T_ABERTA),
    .W     (TW)
  ) u_tmr (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (TW'(T_ABERTA)),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Next-state and output decode. Every strobe is a pure function of the
  // current state, so none can leak into another state and an asynchronous
  // reset drops them (and the barrier) immediately.
  always_comb begin
    estado_d      = estado_q;
    matr_d        = matr_q;
    dia_d         = dia_q;
    idx_d         = idx_q;
    hit_d         = hit_q;
    dia_hit_d     = dia_hit_q;
    tmr_load      = 1'b0;
    tmr_dec       = 1'b0;

    Rd_En         = (estado_q == LER);
    Rd_Addr       = idx_q;
    Clr_En        = (estado_q == LIMPA);
    Clr_Addr      = hit_q;
    Multa         = (estado_q == LIMPA) && (dia_hit_q != dia_q);
    Barreira2     = (estado_q == ABRE);
    NaoEncontrada = (estado_q == FALHA);
    Ocupado       = (estado_q != IDLE);

    case (estado_q)
      IDLE: begin
        if (MatrVal) begin
          matr_d   = Matricula;
          dia_d    = Dia;
          idx_d    = '0;
          estado_d = LER;
        end
      end
      LER: begin
        estado_d = COMP;
      end
      COMP: begin
        // An empty slot never matches, whatever stale plate it still holds.
        if (Rd_Valid && (Rd_Data == matr_q)) begin
          hit_d     = idx_q;
          dia_hit_d = Rd_Dia;
          estado_d  = LIMPA;
        end else if (idx_q == AW'(N_LUG - 1)) begin
          estado_d = FALHA;
        end else begin
          idx_d    = idx_q + AW'(1);
          estado_d = LER;
        end
      end
      LIMPA: begin
        tmr_load = 1'b1;
        estado_d = ABRE;
      end
      ABRE: begin
        // The timer enters ABRE holding T_ABERTA, so leaving on the cycle it
        // reads 1 keeps the barrier up for exactly T_ABERTA cycles.
        tmr_dec = !tmr_zero;
        if (tmr_count <= TW'(1)) begin
          estado_d = IDLE;
        end
      end
      FALHA: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      estado_q  <= IDLE;
      matr_q    <= '0;
      dia_q     <= '0;
      idx_q     <= '0;
      hit_q     <= '0;
      dia_hit_q <= '0;
    end else begin
      estado_q  <= estado_d;
      matr_q    <= matr_d;
      dia_q     <= dia_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      dia_hit_q <= dia_hit_d;
    end
  end

endmodule

// File: tb/tb_leitura_matr.sv
// ---------------------------------------------------------------------------
// tb_leitura_matr
// Bench for leitura_matr. A plate-store model answers the read port, a
// request-level reference model predicts every output from the cycle number
// after accept, and a compare process checks the DUT on every falling edge.
// Directed scenarios add hand-computed literal checks at key cycles.
// ---------------------------------------------------------------------------
module tb_leitura_matr;

  localparam int N_LUG    = 8;
  localparam int AW       = 3;
  localparam int T_ABERTA = 16;

  logic          CLK   = 1'b0;
  logic          RST_N = 1'b1;
  logic [23:0]   Matricula;
  logic          MatrVal;
  logic [2:0]    Dia;
  logic          Rd_En;
  logic [AW-1:0] Rd_Addr;
  logic [23:0]   Rd_Data  = '0;
  logic          Rd_Valid = 1'b0;
  logic [2:0]    Rd_Dia   = '0;
  logic          Clr_En;
  logic [AW-1:0] Clr_Addr;
  logic          Ocupado;
  logic          Barreira2;
  logic          Multa;
  logic          NaoEncontrada;

  logic [23:0]   storeData  [N_LUG];
  logic          storeValid [N_LUG];
  logic [2:0]    storeDia   [N_LUG];

  int            checks    = 0;
  int            errors    = 0;
  int            curCycle  = 0;
  logic          cmpEnable = 1'b0;

  int            modelN    = 0;
  int            modelK    = -1;
  int            modelEnd  = 0;
  logic [2:0]    modelDia  = '0;

  int            cmpN;
  int            cmpK;
  int            cmpLast;
  logic          expRdEn;
  logic          expClr;

  leitura_matr #(
    .N_LUG    (N_LUG),
    .AW       (AW),
    .T_ABERTA (T_ABERTA)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .Matricula     (Matricula),
    .MatrVal       (MatrVal),
    .Dia           (Dia),
    .Rd_En         (Rd_En),
    .Rd_Addr       (Rd_Addr),
    .Rd_Data       (Rd_Data),
    .Rd_Valid      (Rd_Valid),
    .Rd_Dia        (Rd_Dia),
    .Clr_En        (Clr_En),
    .Clr_Addr      (Clr_Addr),
    .Ocupado       (Ocupado),
    .Barreira2     (Barreira2),
    .Multa         (Multa),
    .NaoEncontrada (NaoEncontrada)
  );

  // Free-running 10-unit clock.
  initial forever #5 CLK = ~CLK;

  // First valid slot holding the plate, in ascending order, or -1 if none.
  function automatic int findHit(input logic [23:0] plate);
    for (int i = 0; i < N_LUG; i++) begin
      if (storeValid[i] && (storeData[i] == plate)) return i;
    end
    return -1;
  endfunction

  // Cycle at which the reader is idle again for a hit at slot k or a miss.
  function automatic int endFor(input int k);
    return (k >= 0) ? (2 * k + 4 + T_ABERTA) : (2 * N_LUG + 2);
  endfunction

  function automatic logic [2:0] hitDay(input int k);
    return (k >= 0) ? storeDia[k] : 3'd0;
  endfunction

  task automatic checkOutput(input string name, input int cyc,
                             input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Synchronous-read plate store: data, valid bit and day appear the cycle
  // after a read strobe and hold until the next strobe.
  always @(posedge CLK) begin
    if (Rd_En) begin
      Rd_Data  <= storeData[Rd_Addr];
      Rd_Valid <= storeValid[Rd_Addr];
      Rd_Dia   <= storeDia[Rd_Addr];
    end
  end

  // Request-level reference model: on an accept it resolves the whole search
  // against the store contents and then just counts cycles to the idle cycle.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      modelN <= 0;
    end else if (modelN == 0) begin
      if (MatrVal) begin
        modelN   <= 1;
        modelK   <= findHit(Matricula);
        modelEnd <= endFor(findHit(Matricula));
        modelDia <= Dia;
      end
    end else begin
      modelN <= (modelN + 1 == modelEnd) ? 0 : modelN + 1;
    end
  end

  // Compare process: derives every expected output from the cycle number and
  // the resolved hit slot, and checks the DUT away from the active edge.
  always @(negedge CLK) begin
    if (cmpEnable) begin
      if (!RST_N) begin
        checkOutput("rst_rd_en",    0, Rd_En,         0);
        checkOutput("rst_rd_addr",  0, Rd_Addr,       0);
        checkOutput("rst_clr_en",   0, Clr_En,        0);
        checkOutput("rst_clr_addr", 0, Clr_Addr,      0);
        checkOutput("rst_ocupado",  0, Ocupado,       0);
        checkOutput("rst_barreira", 0, Barreira2,     0);
        checkOutput("rst_multa",    0, Multa,         0);
        checkOutput("rst_nao_enc",  0, NaoEncontrada, 0);
      end else begin
        cmpN    = modelN;
        cmpK    = modelK;
        cmpLast = (cmpK >= 0) ? cmpK : N_LUG - 1;
        expRdEn = (cmpN >= 1) && (cmpN % 2 == 1) && ((cmpN - 1) / 2 <= cmpLast);
        expClr  = (cmpN != 0) && (cmpK >= 0) && (cmpN == 2 * cmpK + 3);
        checkOutput("cmp_rd_en", cmpN, Rd_En, expRdEn);
        if (expRdEn) checkOutput("cmp_rd_addr", cmpN, Rd_Addr, (cmpN - 1) / 2);
        checkOutput("cmp_clr_en", cmpN, Clr_En, expClr);
        if (expClr) checkOutput("cmp_clr_addr", cmpN, Clr_Addr, cmpK);
        checkOutput("cmp_multa", cmpN, Multa,
                    expClr && (hitDay(cmpK) != modelDia));
        checkOutput("cmp_barreira", cmpN, Barreira2,
                    (cmpN != 0) && (cmpK >= 0) && (cmpN >= 2 * cmpK + 4) &&
                    (cmpN <= 2 * cmpK + 3 + T_ABERTA));
        checkOutput("cmp_nao_enc", cmpN, NaoEncontrada,
                    (cmpN != 0) && (cmpK < 0) && (cmpN == 2 * N_LUG + 1));
        checkOutput("cmp_ocupado", cmpN, Ocupado, cmpN != 0);
      end
    end
  end

  // Background store: every slot valid with a plate no scenario searches for.
  task automatic fillStore();
    for (int i = 0; i < N_LUG; i++) begin
      storeValid[i] = 1'b1;
      storeData[i]  = 24'hF00000 | 24'(i);
      storeDia[i]   = 3'(i);
    end
  endtask

  // One-cycle exit request; returns at the falling edge of cycle 1.
  task automatic applyStimulus(input logic [23:0] plate, input logic [2:0] day);
    @(negedge CLK);
    Matricula = plate;
    Dia       = day;
    MatrVal   = 1'b1;
    @(negedge CLK);
    MatrVal   = 1'b0;
    curCycle  = 1;
  endtask

  task automatic toCycle(input int n);
    while (curCycle < n) begin
      @(negedge CLK);
      curCycle++;
    end
  endtask

  // Directed scenarios with literal expectations at the cycles that matter.
  initial begin
    Matricula = '0;
    MatrVal   = 1'b0;
    Dia       = '0;
    fillStore();
    #2 RST_N = 1'b0;
    cmpEnable = 1'b1;
    #1;
    checkOutput("init_ocupado",   0, Ocupado,  0);
    checkOutput("init_rd_addr",   0, Rd_Addr,  0);
    checkOutput("init_clr_addr",  0, Clr_Addr, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] hit in slot 0, same day");
    storeData[0] = 24'hABC123;
    storeDia[0]  = 3'd3;
    applyStimulus(24'hABC123, 3'd3);
    checkOutput("t1_rd_en",     1, Rd_En,     1);
    checkOutput("t1_ocupado",   1, Ocupado,   1);
    toCycle(3);
    checkOutput("t1_clr_en",    3, Clr_En,    1);
    checkOutput("t1_clr_addr",  3, Clr_Addr,  0);
    checkOutput("t1_multa",     3, Multa,     0);
    toCycle(4);
    checkOutput("t1_bar_first", 4, Barreira2, 1);
    toCycle(19);
    checkOutput("t1_bar_last", 19, Barreira2, 1);
    toCycle(20);
    checkOutput("t1_bar_off",  20, Barreira2, 0);
    checkOutput("t1_idle",     20, Ocupado,   0);
    toCycle(21);

    $display("[TB] hit in last slot with a fine");
    fillStore();
    storeData[7] = 24'h123456;
    storeDia[7]  = 3'd2;
    applyStimulus(24'h123456, 3'd5);
    toCycle(17);
    checkOutput("t2_clr_addr", 17, Clr_Addr,  7);
    checkOutput("t2_multa",    17, Multa,     1);
    toCycle(18);
    checkOutput("t2_bar_first", 18, Barreira2, 1);
    toCycle(33);
    checkOutput("t2_bar_last", 33, Barreira2, 1);
    toCycle(35);

    $display("[TB] plate only in an empty slot");
    fillStore();
    storeValid[6] = 1'b0;
    storeData[6]  = 24'h777777;
    applyStimulus(24'h777777, 3'd1);
    toCycle(17);
    checkOutput("t3a_nao_enc", 17, NaoEncontrada, 1);
    checkOutput("t3a_barreira", 17, Barreira2, 0);
    toCycle(18);
    checkOutput("t3a_idle", 18, Ocupado, 0);
    toCycle(19);

    $display("[TB] all-zero plate in an empty slot");
    fillStore();
    storeValid[4] = 1'b0;
    storeData[4]  = 24'h000000;
    applyStimulus(24'h000000, 3'd0);
    toCycle(17);
    checkOutput("t3b_nao_enc", 17, NaoEncontrada, 1);
    toCycle(19);

    $display("[TB] duplicate plate, first slot wins");
    fillStore();
    storeData[2] = 24'hBEEF01;
    storeData[5] = 24'hBEEF01;
    storeDia[2]  = 3'd0;
    storeDia[5]  = 3'd0;
    applyStimulus(24'hBEEF01, 3'd0);
    toCycle(7);
    checkOutput("t4_clr_addr", 7, Clr_Addr, 2);
    checkOutput("t4_rd_en",    7, Rd_En,    0);
    toCycle(25);

    $display("[TB] inputs changed during scan, then back-to-back");
    fillStore();
    storeData[3] = 24'h5A5A03;
    storeDia[3]  = 3'd1;
    storeData[1] = 24'h111111;
    storeDia[1]  = 3'd1;
    applyStimulus(24'h5A5A03, 3'd1);
    toCycle(2);
    Matricula = 24'h111111;
    Dia       = 3'd6;
    toCycle(4);
    MatrVal = 1'b1;
    toCycle(5);
    MatrVal = 1'b0;
    toCycle(9);
    checkOutput("t5_clr_addr", 9, Clr_Addr, 3);
    checkOutput("t5_multa",    9, Multa,    0);
    toCycle(12);
    MatrVal = 1'b1;
    toCycle(26);
    checkOutput("t5_idle", 26, Ocupado, 0);
    toCycle(27);
    MatrVal = 1'b0;
    checkOutput("t5_again_ocup", 27, Ocupado, 1);
    checkOutput("t5_again_rd",   27, Rd_Addr, 0);
    toCycle(31);
    checkOutput("t5_again_clr",   31, Clr_Addr, 1);
    checkOutput("t5_again_multa", 31, Multa,    1);
    toCycle(49);

    $display("[TB] reset in the middle of a scan");
    fillStore();
    storeData[6] = 24'h666666;
    applyStimulus(24'h666666, 3'd6);
    toCycle(10);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("t6_rst_ocup",  10, Ocupado,   0);
    checkOutput("t6_rst_rd_en", 10, Rd_En,     0);
    checkOutput("t6_rst_addr",  10, Rd_Addr,   0);
    checkOutput("t6_rst_clr",   10, Clr_En,    0);
    checkOutput("t6_rst_bar",   10, Barreira2, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    applyStimulus(24'h666666, 3'd6);
    checkOutput("t6_rescan_rd",   1, Rd_En,   1);
    checkOutput("t6_rescan_addr", 1, Rd_Addr, 0);
    toCycle(15);
    checkOutput("t6_clr_en",   15, Clr_En,   1);
    checkOutput("t6_clr_addr", 15, Clr_Addr, 6);
    toCycle(33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
